glitchless_clk_mux: RTL and testbench
=====================================

Name: glitchless_clk_mux

Overview:
- Cycle-based RTL model of a glitch-free 2:1 clock multiplexer/clock-gate cell.
- Two sampled clock inputs (i0, i1) are observed in a fast system clock domain (clk). Output o follows the selected input.
- In SYNC mode, a select change never produces a runt pulse: the output parks at an idle level between sources.
- Used for clock-enable/clock-switch emulation. A clock-enable buffer is built by driving s = ~ce and tying i1 to the idle level.

Parameters:
- CLK_SEL_TYPE, "SYNC": "SYNC" gives glitch-free switching; "ASYNC" gives immediate switching. Any other value is an elaboration error ($fatal).
- INIT_OUT, 0: idle/park level of o.
  - 0: park low; switch while the current source is low (falling-edge style).
  - 1: park high; switch while the current source is high (rising-edge style).
  - Values other than 0 or 1 are an elaboration error.

Ports:
- clk, input, 1: system sampling clock; all state updates on its rising edge.
- rst_n, input, 1: synchronous active-low reset, sampled on rising clk.
- i0, input, 1: sampled clock source 0.
- i1, input, 1: sampled clock source 1.
- s, input, 1: select; 0 selects i0, 1 selects i1.
- o, output, 1: muxed clock, registered.
- sel_o, output, 1: index of the source currently driving o. Valid only when busy = 0.
- busy, output, 1: 1 while parked, i.e. o is forced to INIT_OUT.

Behaviour:
- Constant IDLE = INIT_OUT[0].
- Reset (rst_n = 0 at a clk edge):
  - state = PARK, o = IDLE, busy = 1, sel_o = 0, target = s.
  - Reset wins over all other events and is allowed mid-switch.
- SYNC mode, states ACT0, ACT1, PARK:
  - ACTk (k = 0 or 1):
    - o <= ik; busy = 0; sel_o = k.
    - If s != k and ik == IDLE in the current sample: next state PARK, o <= IDLE, target <= s.
    - If s != k but ik != IDLE: stay in ACTk and keep following ik until ik reaches IDLE. The pulse in progress is never truncated.
  - PARK:
    - o <= IDLE; busy = 1; target <= s every cycle, so a select bounce during PARK retargets.
    - If i_target == IDLE: next state ACT_target. The new source is joined only at its idle level, so the first output edge is a full leading edge.
    - Else remain in PARK.
  - A select pulse that returns to k before ik reaches IDLE causes no switch; the state stays ACTk.
  - A source stuck at the non-idle level keeps the FSM in ACTk (or in PARK for the new source) indefinitely. This is intended: it matches the hardware lock-up on a dead clock.
  - Latency: o reflects the selected input with 1 clk cycle of delay.
- ASYNC mode:
  - o <= (s ? i1 : i0) every cycle; sel_o <= s; busy = 0 except during reset.
  - FSM is held in ACT_s; no parking, glitches are allowed.
- No X-propagation modelling; X or Z on inputs is a don't-care.

Decomposition:
- Package glitchless_clk_mux_pkg:
  - state enum (ACT0, ACT1, PARK);
  - localparams for the legal CLK_SEL_TYPE strings;
  - function idle_level(INIT_OUT).
- Single module; no sub-module. The 2:1 select and the ce inverter are inline logic.

Test Plan:
- Reset and lock, INIT_OUT=0, SYNC:
  - Stimulus: rst_n=0 for 2 cycles with s=0 and i0 toggling every 4 clk; then release.
  - Response: o=0 and busy=1 during reset; enters ACT0 on the first cycle i0==0; o then equals i0 delayed by 1 cycle.
- SYNC switch 0->1, INIT_OUT=0:
  - Stimulus: s rises while i0=1.
  - Response: o keeps following i0 until i0 falls; o=0 and busy=1 until i1 is sampled 0; then o follows i1. No high pulse shorter than the source high time.
- SYNC switch with INIT_OUT=1:
  - Stimulus: same sequence as above.
  - Response: park level is 1; the switch happens only while the current source is high; o=1 throughout PARK.
- Select glitch:
  - Stimulus: s=1 for 1 cycle while i0=1, then back to 0.
  - Response: state stays ACT0; o is identical to i0 delayed by 1 cycle.
- ASYNC mode:
  - Stimulus: s toggles mid-high of i0.
  - Response: o switches to i1 on the next cycle; a runt is permitted; busy stays 0.
- Clock-enable use, INIT_OUT=0, i1 tied 0, s=~ce:
  - Stimulus: ce=0 during i0 high.
  - Response: o completes the high pulse, then stays 0; on ce=1, o resumes on the next i0 low-to-high edge.

Source files
------------

// File: rtl/glitchless_clk_mux_pkg.sv
// Shared types and helpers for the glitch-free 2:1 clock mux.
// Holds the FSM state encoding, legal select-type names and idle-level helper.
package glitchless_clk_mux_pkg;

   typedef enum logic [1:0] {
      ACT0 = 2'd0,
      ACT1 = 2'd1,
      PARK = 2'd2
   } state_e;

   localparam string SEL_SYNC  = "SYNC";
   localparam string SEL_ASYNC = "ASYNC";

   // Park level of the output; only bit 0 of INIT_OUT is meaningful.
   function automatic logic idle_level(input int init_out);
      return init_out[0];
   endfunction

endpackage

// File: rtl/glitchless_clk_mux_if.sv
// Signal bundle between a clock-switch controller and the mux.
// master: drives sources i0/i1 and select s; slave: returns o, sel_o, busy.
interface glitchless_clk_mux_if;

   logic i0;
   logic i1;
   logic s;
   logic o;
   logic sel_o;
   logic busy;

   modport master (
      output i0,
      output i1,
      output s,
      input  o,
      input  sel_o,
      input  busy
   );

   modport slave (
      input  i0,
      input  i1,
      input  s,
      output o,
      output sel_o,
      output busy
   );

endinterface

// File: rtl/glitchless_clk_mux.sv
// Cycle-based glitch-free 2:1 clock mux / clock gate, sampled on clk.
// Ports: clk, rst_n (sync, active low), bus (slave: i0, i1, s in; o, sel_o, busy out).
module glitchless_clk_mux
   import glitchless_clk_mux_pkg::*;
#(
   parameter string CLK_SEL_TYPE = "SYNC",
   parameter int    INIT_OUT     = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   glitchless_clk_mux_if.slave  bus
);

   if (CLK_SEL_TYPE != SEL_SYNC && CLK_SEL_TYPE != SEL_ASYNC) begin : g_bad_type
      $fatal(1, "glitchless_clk_mux: CLK_SEL_TYPE must be SYNC or ASYNC");
   end

   if (INIT_OUT != 0 && INIT_OUT != 1) begin : g_bad_init
      $fatal(1, "glitchless_clk_mux: INIT_OUT must be 0 or 1");
   end

   localparam logic IDLE     = idle_level(INIT_OUT);
   localparam bit   IS_ASYNC = (CLK_SEL_TYPE == SEL_ASYNC);

   state_e state;
   logic   target;
   logic   o_q;
   logic   sel_q;
   logic   busy_q;
   logic   i_tgt;

   // Source requested on entry to PARK; joined only once it sits at IDLE.
   assign i_tgt = target ? bus.i1 : bus.i0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= PARK;
         o_q    <= IDLE;
         busy_q <= 1'b1;
         sel_q  <= 1'b0;
         target <= bus.s;
      end else if (IS_ASYNC) begin
         state  <= bus.s ? ACT1 : ACT0;
         o_q    <= bus.s ? bus.i1 : bus.i0;
         sel_q  <= bus.s;
         busy_q <= 1'b0;
         target <= bus.s;
      end else begin
         target <= bus.s;
         unique case (state)
            ACT0: begin
               // Leave only at the idle level so the running pulse completes.
               if (bus.s && bus.i0 == IDLE) begin
                  state  <= PARK;
                  o_q    <= IDLE;
                  busy_q <= 1'b1;
               end else begin
                  o_q    <= bus.i0;
                  busy_q <= 1'b0;
                  sel_q  <= 1'b0;
               end
            end
            ACT1: begin
               if (!bus.s && bus.i1 == IDLE) begin
                  state  <= PARK;
                  o_q    <= IDLE;
                  busy_q <= 1'b1;
               end else begin
                  o_q    <= bus.i1;
                  busy_q <= 1'b0;
                  sel_q  <= 1'b1;
               end
            end
            PARK: begin
               o_q <= IDLE;
               if (i_tgt == IDLE) begin
                  state  <= target ? ACT1 : ACT0;
                  busy_q <= 1'b0;
                  sel_q  <= target;
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state  <= PARK;
               o_q    <= IDLE;
               busy_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.o     = o_q;
   assign bus.sel_o = sel_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_glitchless_clk_mux.sv
// Directed bench for glitchless_clk_mux: SYNC/INIT 0, SYNC/INIT 1 and ASYNC.
// All three instances share stimulus; each scenario checks its own instance.
module tb_glitchless_clk_mux;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i0 = 1'b0;
   logic i1 = 1'b0;
   logic s = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   glitchless_clk_mux_if if_a ();
   glitchless_clk_mux_if if_b ();
   glitchless_clk_mux_if if_c ();

   assign if_a.i0 = i0;
   assign if_a.i1 = i1;
   assign if_a.s  = s;
   assign if_b.i0 = i0;
   assign if_b.i1 = i1;
   assign if_b.s  = s;
   assign if_c.i0 = i0;
   assign if_c.i1 = i1;
   assign if_c.s  = s;

   glitchless_clk_mux #(.CLK_SEL_TYPE("SYNC"), .INIT_OUT(0)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   glitchless_clk_mux #(.CLK_SEL_TYPE("SYNC"), .INIT_OUT(1)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   glitchless_clk_mux #(.CLK_SEL_TYPE("ASYNC"), .INIT_OUT(0)) u_c (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_c)
   );

   // Vector fields: {i0, i1, s, expected o, expected busy}.
   localparam logic [4:0] TV_LOCK [10] = '{
      5'b10001, 5'b10001, 5'b00000, 5'b00000, 5'b00000,
      5'b00000, 5'b10010, 5'b10010, 5'b10010, 5'b10010
   };

   localparam logic [4:0] TV_SW0 [11] = '{
      5'b00000, 5'b10010, 5'b10110, 5'b10110, 5'b01101, 5'b01101,
      5'b01101, 5'b00100, 5'b01110, 5'b01110, 5'b00100
   };

   localparam logic [4:0] TV_SW1 [10] = '{
      5'b00011, 5'b10010, 5'b00000, 5'b00100, 5'b00100,
      5'b10111, 5'b00111, 5'b01110, 5'b00100, 5'b01110
   };

   localparam logic [4:0] TV_GLITCH [8] = '{
      5'b00000, 5'b10010, 5'b10110, 5'b10010,
      5'b00000, 5'b00000, 5'b10010, 5'b00000
   };

   localparam logic [4:0] TV_ASYNC [6] = '{
      5'b10010, 5'b10100, 5'b11110, 5'b01000, 5'b01110, 5'b10100
   };

   localparam logic [4:0] TV_CE [12] = '{
      5'b00000, 5'b10010, 5'b10110, 5'b10110, 5'b00101, 5'b10100,
      5'b00100, 5'b10100, 5'b10001, 5'b10001, 5'b00000, 5'b10010
   };

   // Inputs change on the falling edge; outputs are read one full cycle later.
   task automatic step(input logic vi0, input logic vi1, input logic vs);
      i0 = vi0;
      i1 = vi1;
      s  = vs;
      @(negedge clk);
   endtask

   task automatic do_reset(input logic vi0, input logic vs);
      rst_n = 1'b0;
      step(vi0, 1'b0, vs);
      step(vi0, 1'b0, vs);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [4:0] v;
      do_reset(1'b1, 1'b0);
      checks++;
      if (if_a.o !== 1'b0 || if_a.busy !== 1'b1 || if_a.sel_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: o/busy/sel=%b%b%b expected 010",
                  if_a.o, if_a.busy, if_a.sel_o);
      end
      checks++;
      if (if_b.o !== 1'b1 || if_b.busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_b: o/busy=%b%b expected 11", if_b.o, if_b.busy);
      end
      checks++;
      if (if_c.o !== 1'b0 || if_c.busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_c: o/busy=%b%b expected 01", if_c.o, if_c.busy);
      end
      for (int k = 0; k < 10; k++) begin
         v = TV_LOCK[k];
         step(v[4], v[3], v[2]);
         checks++;
         if (if_a.o !== v[1] || if_a.busy !== v[0]) begin
            errors++;
            $display("FAIL lock step %0d: o/busy=%b%b expected %b%b",
                     k, if_a.o, if_a.busy, v[1], v[0]);
         end
      end
   endtask

   task automatic test_switch_init0();
      logic [4:0] v;
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 11; k++) begin
         v = TV_SW0[k];
         step(v[4], v[3], v[2]);
         checks++;
         if (if_a.o !== v[1] || if_a.busy !== v[0]) begin
            errors++;
            $display("FAIL switch0 step %0d: o/busy=%b%b expected %b%b",
                     k, if_a.o, if_a.busy, v[1], v[0]);
         end
      end
      checks++;
      if (if_a.sel_o !== 1'b1) begin
         errors++;
         $display("FAIL switch0 sel_o: got %b expected 1", if_a.sel_o);
      end
   endtask

   task automatic test_switch_init1();
      logic [4:0] v;
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         v = TV_SW1[k];
         step(v[4], v[3], v[2]);
         checks++;
         if (if_b.o !== v[1] || if_b.busy !== v[0]) begin
            errors++;
            $display("FAIL switch1 step %0d: o/busy=%b%b expected %b%b",
                     k, if_b.o, if_b.busy, v[1], v[0]);
         end
      end
      checks++;
      if (if_b.sel_o !== 1'b1) begin
         errors++;
         $display("FAIL switch1 sel_o: got %b expected 1", if_b.sel_o);
      end
   endtask

   task automatic test_select_glitch();
      logic [4:0] v;
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         v = TV_GLITCH[k];
         step(v[4], v[3], v[2]);
         checks++;
         if (if_a.o !== v[1] || if_a.busy !== v[0] || if_a.sel_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch step %0d: o/busy/sel=%b%b%b expected %b%b0",
                     k, if_a.o, if_a.busy, if_a.sel_o, v[1], v[0]);
         end
      end
   endtask

   task automatic test_async();
      logic [4:0] v;
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         v = TV_ASYNC[k];
         step(v[4], v[3], v[2]);
         checks++;
         if (if_c.o !== v[1] || if_c.busy !== v[0] || if_c.sel_o !== v[2]) begin
            errors++;
            $display("FAIL async step %0d: o/busy/sel=%b%b%b expected %b%b%b",
                     k, if_c.o, if_c.busy, if_c.sel_o, v[1], v[0], v[2]);
         end
      end
   endtask

   task automatic test_clock_enable();
      logic [4:0] v;
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         v = TV_CE[k];
         step(v[4], v[3], v[2]);
         checks++;
         if (if_a.o !== v[1] || if_a.busy !== v[0]) begin
            errors++;
            $display("FAIL ce step %0d: o/busy=%b%b expected %b%b",
                     k, if_a.o, if_a.busy, v[1], v[0]);
         end
      end
   endtask

   task automatic test_stuck_and_reset();
      do_reset(1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 1'b1);
         checks++;
         if (if_a.o !== 1'b1 || if_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL stuck_src %0d: o/busy=%b%b expected 10",
                     k, if_a.o, if_a.busy);
         end
      end
      step(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b1);
         checks++;
         if (if_a.o !== 1'b0 || if_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL stuck_park %0d: o/busy=%b%b expected 01",
                     k, if_a.o, if_a.busy);
         end
      end
      rst_n = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      checks++;
      if (if_a.o !== 1'b0 || if_a.busy !== 1'b1 || if_a.sel_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: o/busy/sel=%b%b%b expected 010",
                  if_a.o, if_a.busy, if_a.sel_o);
      end
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (if_a.busy !== 1'b0 || if_a.sel_o !== 1'b0) begin
         errors++;
         $display("FAIL relock: busy/sel=%b%b expected 00",
                  if_a.busy, if_a.sel_o);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_switch_init0();
      test_switch_init1();
      test_select_glitch();
      test_async();
      test_clock_enable();
      test_stuck_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
